uart_console_rx: RTL and testbench
==================================

// Module: uart_console_rx
// PURPOSE
//  Serial 8N1 receiver that consumes the UART tx line driven by wb_uart_wrapper and
//  delivers received bytes over a valid/ready stream through a small FWFT FIFO.
//  Sits downstream of the UART in the generic OR1200 SoC. Feeds the console printer /
//  test-result checker in simulation and a host-bridge in hardware.
// PARAMETERS
//  DIVISOR       26  clocks per oversample tick (16 ticks per bit); legal range 1..65535
//  FIFO_AW       4   log2 FIFO depth (depth = 2**FIFO_AW)
// PORTS
//  wb_clk_i      in   1          system clock; single clock domain
//  wb_rst_n_i    in   1          asynchronous active-low reset
//  rx_i          in   1          serial line, idle high, async to wb_clk_i
//  data_o        out  8          head-of-FIFO byte
//  valid_o       out  1          FIFO not empty
//  ready_i       in   1          consumer accepts data_o when valid_o && ready_i
//  count_o       out  FIFO_AW+1  FIFO occupancy
//  frame_err_o   out  1          one-cycle pulse: stop bit sampled low
//  overrun_o     out  1          one-cycle pulse: byte dropped, FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, data_o 0, FIFO empty, FSM IDLE, synchroniser flops = 1.
//  rx_i passes a 2-flop synchroniser (rx_s). Edge detection and sampling use rx_s only.
//  Tick counter: counts DIVISOR-1 down to 0; tick = 1 cycle when 0, then reloads.
//  - Counter is reloaded on the IDLE->START transition, so bit timing aligns to the edge.
//  Phase counter (4b) counts ticks within a bit. Sample point is phase==7 (mid-bit).
//  FSM states and transitions:
//  - IDLE: rx_s 1->0 edge -> START. Reload the tick and phase counters.
//  - START: at mid-bit, rx_s==0 -> DATA with bit index 0. rx_s==1 -> IDLE (glitch, no pulse).
//  - DATA: sample rx_s at each mid-bit, LSB first into a shift register.
//    After bit 7 -> STOP.
//  - STOP, at mid-bit:
//    - rx_s==1: push the byte. Go to IDLE immediately (back-to-back frames need
//      no extra idle time).
//    - rx_s==0: frame_err_o pulse, byte discarded -> WAIT_HI.
//  - WAIT_HI: stay until rx_s==1, then IDLE. A break (line held low) yields exactly one
//    frame_err_o pulse.
//  Latency: push occurs in the stop-sample cycle. valid_o/data_o update the next cycle.
//  FIFO rules:
//  - FWFT. Pop = valid_o && ready_i. data_o is stable while valid_o && !ready_i.
//  - Push when full and no pop: byte dropped, overrun_o pulse, contents unchanged.
//  - Push and pop in the same cycle when full: both occur, no overrun, count unchanged.
//  - Push and pop in the same cycle when count==1: new byte presented the next cycle,
//    valid_o stays 1.
//  - Pointers are FIFO_AW bits and wrap naturally. count_o = push-minus-pop accounting,
//    saturates at no value (it can never exceed 2**FIFO_AW).
//  frame_err_o and overrun_o never assert in the same cycle: a framing error never pushes.
//  Reset mid-frame: async clear to IDLE, partial byte lost. The FIFO is cleared.
//  - After reset release, a line already low does not start a frame; a 1->0 edge is needed.
// STRUCTURE
//  Shared package uart_console_pkg: FSM state encoding (IDLE, START, DATA, STOP, WAIT_HI),
//  SAMPLE_PHASE=7, TICKS_PER_BIT=16.
//  One sub-module: uart_console_fifo (FWFT sync FIFO, params FIFO_AW, width 8, same
//  clock/reset). Synchroniser, tick generator and FSM stay in the top.
// TESTING  (DIVISOR=4 -> 64 clocks/bit, FIFO_AW=2)
//  1. Byte 0x55 drive:
//     - Drive 0x55 8N1 with ready_i=1.
//     - valid_o high 1 cycle after the stop mid-sample, data_o=0x55, count_o 0->1->0.
//     - No error pulses.
//  2. Back-to-back frames:
//     - Drive 0x41,0x42,0x43 with no idle between them, ready_i=0.
//     - count_o=3. Pops yield 0x41,0x42,0x43 in order.
//  3. Overrun:
//     - With ready_i=0, send 5 bytes 0x01..0x05.
//     - count_o=4. One overrun_o pulse at the 5th stop sample. Pops yield 0x01..0x04.
//  4. Framing error and break:
//     - Byte 0xA5 with the stop bit forced 0 -> one frame_err_o pulse, count_o unchanged.
//     - Hold the line low 1000 clocks -> no further pulses.
//     - Release, then send 0x3C -> received correctly.
//  5. Start glitch:
//     - A 20-clock low pulse on rx_i -> FSM returns to IDLE, no push, no pulses.
//     - Next 0x7E frame is received intact.
//  6. Reset and full-FIFO boundary:
//     - Assert wb_rst_n_i mid-DATA of 0xFF -> outputs 0, FIFO empty. After release, 0x81
//       is received.
//     - Full FIFO with ready_i=1 at a push -> no overrun, count_o stays 4.

Source files
------------

// File: rtl/uart_console_pkg.sv
// Shared definitions for the console UART receiver and its FIFO.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_console_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_e;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned SAMPLE_PHASE  = 7;
  localparam int unsigned BYTE_W        = 8;

endpackage

// File: rtl/uart_console_fifo.sv
// First-word-fall-through byte FIFO between the receiver and the console consumer.
// Latency: a pushed byte is visible on rd_dat/rd_vld the cycle after the push.
// Backpressure: rd_rdy low holds the head; a push while full without a pop is dropped and flagged on ovf.
module uart_console_fifo
  import uart_console_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_vld,
  input  logic [BYTE_W-1:0] wr_dat,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [BYTE_W-1:0] rd_dat,
  output logic [FIFO_AW:0]  count,
  output logic              ovf
);

  localparam int unsigned        DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [BYTE_W-1:0]  mem_q [DEPTH];
  logic [BYTE_W-1:0]  mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full;
  logic               pop;
  logic               do_push;

  // A pop frees the slot the push needs, so push-while-full is only dropped without a pop
  assign full    = (count_q == FULL_CNT);
  assign rd_vld  = (count_q != '0);
  assign pop     = rd_vld & rd_rdy;
  assign do_push = wr_vld & (~full | pop);
  assign ovf     = wr_vld & full & ~pop;
  assign rd_dat  = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head byte reads 0 while empty after reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_console_rx.sv
// 8N1 serial receiver with 16x oversampling feeding a FWFT byte stream to the console.
// Latency: byte pushed in the stop-bit mid-sample cycle; valid_o/data_o update the cycle after.
// Backpressure: ready_i low holds the head byte; bytes arriving at a full FIFO are dropped with overrun_o.
module uart_console_rx
  import uart_console_pkg::*;
#(
  parameter int unsigned DIVISOR = 26,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              rx_i,
  output logic [7:0]        data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [FIFO_AW:0]  count_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int unsigned        PHASE_W     = $clog2(TICKS_PER_BIT);
  localparam logic [15:0]        TICK_RELOAD = 16'(DIVISOR - 1);
  localparam logic [PHASE_W-1:0] SAMPLE_AT   = PHASE_W'(SAMPLE_PHASE);
  localparam logic [PHASE_W-1:0] PHASE_ONE   = PHASE_W'(1);
  localparam logic [1:0]         SETTLED     = 2'd2;

  logic               rx_meta_q, rx_meta_d;
  logic               rx_s_q, rx_s_d;
  logic               rx_prev_q, rx_prev_d;
  logic [1:0]         settle_q, settle_d;
  logic               armed_q, armed_d;
  rx_state_e          state_q, state_d;
  logic [15:0]        tick_cnt_q, tick_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;

  logic fall_edge;
  logic tick;
  logic mid_bit;
  logic push;
  logic frame_err;

  // The synchroniser resets high, so edges are only trusted once the chain has
  // flushed and the real line has been seen high; a line held low through reset
  // therefore never starts a frame.
  assign fall_edge = armed_q & rx_prev_q & ~rx_s_q;
  assign tick      = (tick_cnt_q == '0);
  assign mid_bit   = tick & (phase_q == SAMPLE_AT);

  // Synchroniser, edge-history and arming next-state
  always_comb begin
    rx_meta_d = rx_i;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    settle_d  = settle_q;
    if (settle_q != SETTLED) begin
      settle_d = settle_q + 2'd1;
    end
    armed_d = armed_q | ((settle_q == SETTLED) & rx_s_q);
  end

  // Receive FSM, oversample tick and phase counters, shift register
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_err  = 1'b0;

    if (state_q != ST_IDLE) begin
      if (tick) begin
        tick_cnt_d = TICK_RELOAD;
        phase_d    = phase_q + PHASE_ONE;
      end else begin
        tick_cnt_d = tick_cnt_q - 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d    = ST_START;
          tick_cnt_d = TICK_RELOAD;
          phase_d    = '0;
        end
      end
      ST_START: begin
        if (mid_bit) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (mid_bit) begin
          shift_d   = {rx_s_q, shift_q[BYTE_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (mid_bit) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; synchroniser and edge history reset to the idle (high) level
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      settle_q   <= 2'd0;
      armed_q    <= 1'b0;
      state_q    <= ST_IDLE;
      tick_cnt_q <= TICK_RELOAD;
      phase_q    <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= '0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  assign frame_err_o = frame_err;

  uart_console_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .wr_vld  (push),
    .wr_dat  (shift_q),
    .rd_vld  (valid_o),
    .rd_rdy  (ready_i),
    .rd_dat  (data_o),
    .count   (count_o),
    .ovf     (overrun_o)
  );

endmodule

// File: tb/tb_uart_console_rx.sv
// Scoreboard bench for uart_console_rx at DIVISOR=4 (64 clocks per bit), FIFO_AW=2.
// Latency: stimulus queues expected bytes at frame launch; the monitor compares on every pop.
// Backpressure: ready_i is driven by the stimulus to exercise fill, overrun and drain.
module tb_uart_console_rx;

  localparam int BIT_CLKS = 64;
  // start edge: 2 sync flops + 1 edge-detect register, then 8 ticks of 4 clocks to
  // mid-start (35); the stop sample is 9 bits later (35 + 9*64); valid one cycle on
  localparam int PUSH_LAT = 611;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [2:0] count;
  logic       ferr;
  logic       ovr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int launch_cyc = 0;
  int first_valid_cyc = -1;
  int valid_cycles = 0;
  int pop_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int max_count = 0;
  logic [7:0] exp_q[$];

  uart_console_rx #(.DIVISOR(4), .FIFO_AW(2)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .count_o     (count),
    .frame_err_o (ferr),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and compares every popped byte against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      if (ferr && ovr) check("err_pulses_exclusive", 32'(ovr), 32'(0));
      if (32'(count) > max_count) max_count = 32'(count);
      if (valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (valid && ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("pop_with_empty_scoreboard", 32'(exp_q.size()), 32'(1));
        else check("pop_data", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One 8N1 frame; the stop bit lasts 63 clocks plus the next call's alignment edge,
  // so consecutive calls produce back-to-back frames.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit expect_push);
    @(posedge clk); #1;
    rx = 1'b0;
    launch_cyc = cyc;
    if (expect_push) exp_q.push_back(b);
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (BIT_CLKS - 1) @(posedge clk);
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    ready = 1'b1;
    for (int i = 0; i < 40 && count != 3'd0; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_drained_count"}, 32'(count), 32'(0));
    check({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'(0));
    ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, v0, p0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("reset_valid", 32'(valid), 32'(0));
    check("reset_count", 32'(count), 32'(0));
    check("reset_data", 32'(data), 32'(0));
    check("reset_frame_err", 32'(ferr), 32'(0));
    check("reset_overrun", 32'(ovr), 32'(0));
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;

    // 1. Single byte, consumer always ready
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
    first_valid_cyc = -1; max_count = 0;
    ready = 1'b1;
    send_byte(8'h55, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("t1_push_latency", 32'(first_valid_cyc - launch_cyc), 32'(PUSH_LAT));
    check("t1_valid_cycles", 32'(valid_cycles - v0), 32'(1));
    check("t1_max_count", 32'(max_count), 32'(1));
    check("t1_count_after", 32'(count), 32'(0));
    check("t1_no_frame_err", 32'(ferr_cnt - f0), 32'(0));
    check("t1_no_overrun", 32'(ovr_cnt - o0), 32'(0));
    check("t1_scoreboard_empty", 32'(exp_q.size()), 32'(0));
    ready = 1'b0;

    // 2. Back-to-back frames held in the FIFO
    send_byte(8'h41, 1'b1, 1'b1);
    send_byte(8'h42, 1'b1, 1'b1);
    send_byte(8'h43, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("t2_count", 32'(count), 32'(3));
    check("t2_head", 32'(data), 32'h41);
    drain("t2");

    // 3. Overrun on the fifth byte
    o0 = ovr_cnt; f0 = ferr_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, i <= 4);
    repeat (20) @(posedge clk); #1;
    check("t3_count_full", 32'(count), 32'(4));
    check("t3_overrun_pulses", 32'(ovr_cnt - o0), 32'(1));
    check("t3_no_frame_err", 32'(ferr_cnt - f0), 32'(0));
    drain("t3");

    // 4. Framing error followed by a break, then recovery
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_byte(8'hA5, 1'b0, 1'b0);
    repeat (1000) @(posedge clk); #1;
    check("t4_frame_err_pulses", 32'(ferr_cnt - f0), 32'(1));
    check("t4_count_unchanged", 32'(count), 32'(0));
    rx = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("t4_break_single_pulse", 32'(ferr_cnt - f0), 32'(1));
    check("t4_no_overrun", 32'(ovr_cnt - o0), 32'(0));
    ready = 1'b1;
    send_byte(8'h3C, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("t4_recovered", 32'(exp_q.size()), 32'(0));
    ready = 1'b0;

    // 5. Short low glitch must not produce a byte
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
    ready = 1'b1;
    rx = 1'b0;
    repeat (20) @(posedge clk); #1;
    rx = 1'b1;
    repeat (200) @(posedge clk); #1;
    check("t5_glitch_no_valid", 32'(valid_cycles - v0), 32'(0));
    check("t5_glitch_no_ferr", 32'(ferr_cnt - f0), 32'(0));
    check("t5_glitch_no_ovr", 32'(ovr_cnt - o0), 32'(0));
    send_byte(8'h7E, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("t5_next_frame", 32'(exp_q.size()), 32'(0));
    check("t5_one_valid", 32'(valid_cycles - v0), 32'(1));
    ready = 1'b0;

    // 6a. Reset in the middle of a frame with a byte already queued
    send_byte(8'h11, 1'b1, 1'b0);
    repeat (10) @(posedge clk); #1;
    check("t6_prefill", 32'(count), 32'(1));
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk); #1;
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("t6_rst_valid", 32'(valid), 32'(0));
    check("t6_rst_count", 32'(count), 32'(0));
    check("t6_rst_data", 32'(data), 32'(0));
    check("t6_rst_errs", 32'({ferr, ovr}), 32'(0));
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    f0 = ferr_cnt; v0 = valid_cycles;
    repeat (700) @(posedge clk); #1;
    check("t6_partial_lost", 32'(valid_cycles - v0), 32'(0));

    // 6b. Line already low when reset releases: no frame may start
    rst_n = 1'b0;
    rx = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (1000) @(posedge clk); #1;
    check("t6_low_line_no_ferr", 32'(ferr_cnt - f0), 32'(0));
    check("t6_low_line_no_valid", 32'(valid_cycles - v0), 32'(0));
    rx = 1'b1;
    repeat (20) @(posedge clk); #1;
    ready = 1'b1;
    send_byte(8'h81, 1'b1, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("t6_after_reset_byte", 32'(exp_q.size()), 32'(0));
    ready = 1'b0;

    // 6c. Push into a full FIFO while the consumer pops in the same cycle
    for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 1'b1, 1'b1);
    o0 = ovr_cnt; p0 = pop_cnt;
    fork
      send_byte(8'h94, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
      end
    join
    repeat (20) @(posedge clk); #1;
    check("t6_full_count_stays", 32'(count), 32'(4));
    check("t6_full_no_overrun", 32'(ovr_cnt - o0), 32'(0));
    check("t6_full_one_pop", 32'(pop_cnt - p0), 32'(1));
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
